// File: rtl/kmp_failure_table.sv
// KMP failure-function generator: latches a pattern, builds its prefix table one
// character comparison per cycle, then holds the packed table for the matcher.
module kmp_failure_table #(
    parameter int BYTE        = 8,
    parameter int MAX_PATTERN = 8,
    parameter int MAX_PAT_ADD = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [MAX_PATTERN*BYTE-1:0]        pat_in,
    input  logic [MAX_PAT_ADD-1:0]             pat_last_idx,
    output logic                               busy,
    output logic                               done,
    output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result
);

    localparam logic [MAX_PAT_ADD-1:0] IDX_ONE = MAX_PAT_ADD'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BYTE-1:0]        pat_q [MAX_PATTERN];
    logic [BYTE-1:0]        pat_d [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] ff_q  [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] ff_d  [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] last_q, last_d;
    logic [MAX_PAT_ADD-1:0] i_q, i_d;
    logic [MAX_PAT_ADD-1:0] k_q, k_d;
    logic                   chars_eq;
    logic                   last_step;

    // A mismatch with k=0 also writes entry i, so it can finish the table too.
    always_comb begin
        chars_eq  = (pat_q[i_q] == pat_q[k_q]);
        last_step = (chars_eq || (k_q == '0)) && (i_q == last_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (pat_last_idx == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            CALC: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pat_d  = pat_q;
        ff_d   = ff_q;
        last_d = last_q;
        i_d    = i_q;
        k_d    = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int j = 0; j < MAX_PATTERN; j++) begin
                        pat_d[j] = pat_in[j*BYTE +: BYTE];
                        ff_d[j]  = '0;
                    end
                    last_d = pat_last_idx;
                    i_d    = IDX_ONE;
                    k_d    = '0;
                end
            end
            CALC: begin
                if (chars_eq) begin
                    k_d       = k_q + IDX_ONE;
                    ff_d[i_q] = k_q + IDX_ONE;
                    if (i_q != last_q) begin
                        i_d = i_q + IDX_ONE;
                    end
                end else if (k_q != '0) begin
                    // Fall back to the next shorter border; i stays put.
                    k_d = ff_q[k_q - IDX_ONE];
                end else begin
                    ff_d[i_q] = '0;
                    if (i_q != last_q) begin
                        i_d = i_q + IDX_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < MAX_PATTERN; j++) begin
                pat_q[j] <= '0;
                ff_q[j]  <= '0;
            end
            last_q <= '0;
            i_q    <= IDX_ONE;
            k_q    <= '0;
        end else begin
            pat_q  <= pat_d;
            ff_q   <= ff_d;
            last_q <= last_d;
            i_q    <= i_d;
            k_q    <= k_d;
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_PATTERN; gi++) begin : g_pack
            assign ff_result[gi*MAX_PAT_ADD +: MAX_PAT_ADD] = ff_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_kmp_failure_table.sv
// Scoreboard bench for kmp_failure_table: stimulus pushes reference tables,
// a negedge monitor pops and compares them whenever done is seen.
module tb_kmp_failure_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] pat_in;
    logic [2:0]  pat_last_idx;
    logic        busy;
    logic        done;
    logic [23:0] ff_result;

    always #5 clk = ~clk;

    kmp_failure_table #(
        .BYTE        (8),
        .MAX_PATTERN (8),
        .MAX_PAT_ADD (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pat_in       (pat_in),
        .pat_last_idx (pat_last_idx),
        .busy         (busy),
        .done         (done),
        .ff_result    (ff_result)
    );

    typedef struct {
        logic [23:0] tbl;
        int          last;
        int          exp_off;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          cyc     = 0;
    int          tests   = 0;
    int          fails   = 0;
    int          to_req  = 0;
    int          to_seen = 0;
    bit          end_req  = 1'b0;
    bit          end_done = 1'b0;
    logic [23:0] held     = '0;
    bit          rst_prev = 1'b0;
    bit          acc_pend = 1'b0;
    bit          done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] str2pat(input string s);
        logic [63:0] p = '0;
        for (int j = 0; j < s.len() && j < 8; j++) p[j*8 +: 8] = s[j];
        return p;
    endfunction

    // Brute force from the definition: longest proper prefix that is also a suffix.
    function automatic logic [23:0] ref_tbl(input logic [63:0] p, input int last);
        logic [23:0] t = '0;
        logic [7:0]  c [8];
        for (int j = 0; j < 8; j++) c[j] = p[j*8 +: 8];
        for (int j = 1; j <= last; j++) begin
            bit found = 1'b0;
            for (int l = j; l >= 1; l--) begin
                bit ok = 1'b1;
                for (int m = 0; m < l; m++) begin
                    if (c[m] != c[j-l+1+m]) ok = 1'b0;
                end
                if (ok && !found) begin
                    t[j*3 +: 3] = 3'(l);
                    found = 1'b1;
                end
            end
        end
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        int   off;
        if (rst_prev) begin
            chk("reset_busy", int'(busy), 0);
            chk("reset_done", int'(done), 0);
            chk("reset_table", int'(ff_result), 0);
        end else begin
            if (acc_pend) chk("accept_busy", int'(busy), 1);
            if (done) begin
                chk("done_busy", int'(busy), 1);
                chk("done_pulse_width", int'(done_prev), 0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pending job");
                end else begin
                    e   = sb.pop_front();
                    off = cyc - e.t0 + 1;
                    $display("[TB] job t0=%0d last=%0d done_at=T+%0d table=0x%06h exp=0x%06h",
                             e.t0, e.last, off, ff_result, e.tbl);
                    chk("table", int'(ff_result), int'(e.tbl));
                    if (e.exp_off >= 0) begin
                        chk("latency", off, e.exp_off);
                    end else begin
                        tests++;
                        if (off < e.last + 1 || off > 2 * e.last + 1) begin
                            fails++;
                            $display("[TB] FAIL latency_bound: got T+%0d expected T+%0d..T+%0d",
                                     off, e.last + 1, 2 * e.last + 1);
                        end
                    end
                    held = e.tbl;
                end
            end else if (!busy) begin
                chk("table_stable", int'(ff_result), int'(held));
            end
        end
        if (to_req != to_seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL stimulus_timeout: got %0d timeouts expected 0", to_req);
            to_seen = to_req;
        end
        if (end_req && !end_done) begin
            chk("scoreboard_drained", sb.size(), 0);
            end_done = 1'b1;
        end
        if (reset) held = '0;
        acc_pend  = start && !busy && !reset;
        rst_prev  = reset;
        done_prev = done;
    end

    task automatic issue(input logic [63:0] p, input logic [2:0] last,
                         input int exp_off, input bit track);
        int w = 0;
        @(posedge clk); #1;
        while (busy && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (busy) to_req++;
        pat_in       = p;
        pat_last_idx = last;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (track) sb.push_back('{tbl: ref_tbl(p, int'(last)), last: int'(last),
                                  exp_off: exp_off, t0: cyc});
        // Only the latched copies may matter from here on.
        pat_in       = {$urandom, $urandom};
        pat_last_idx = 3'($urandom_range(0, 7));
    endtask

    initial begin
        logic [63:0] p;
        int          w;
        reset        = 1'b1;
        start        = 1'b1;
        pat_in       = str2pat("ABAB");
        pat_last_idx = 3'd3;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;

        issue(str2pat("ABAB"), 3'd3, 4, 1'b1);
        issue(str2pat("AABAAA"), 3'd5, 8, 1'b1);
        issue(str2pat("X"), 3'd0, 1, 1'b1);
        issue(str2pat("AAAAAAAA"), 3'd7, 8, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 8; j++) p[j*8 +: 8] = 8'h41 + 8'($urandom_range(0, 2));
            issue(p, 3'($urandom_range(0, 7)), -1, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Spurious starts during CALC and during the done cycle must be dropped.
        issue(str2pat("AABAAA"), 3'd5, 8, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        pat_in = str2pat("ZZZZZZZZ");
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!done && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!done) to_req++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // Abort a job with reset mid-run: it must never report done.
        issue(str2pat("AAAAAAAA"), 3'd7, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);

        issue(str2pat("ABAB"), 3'd3, 4, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        end_req = 1'b1;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
